// File: rtl/ham_pkg.sv
// Shared widths, FSM state type and injection constant for the Hamming(7,4) transmit path.
package ham_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CW_W   = 7;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BIT_W  = 3;

    localparam logic [BIT_W-1:0] NO_INJ   = 3'd7;
    localparam logic [BIT_W-1:0] LAST_BIT = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/ham_encode_comb.sv
// Hamming(7,4) encoder: even parity, layout {d3,d2,d1,p4,d0,p2,p1}, the inverse of the team decoder.
module ham_encode_comb
    import ham_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   cw_o
);

    logic p1, p2, p4;

    always_comb begin
        p1   = data_i[0] ^ data_i[1] ^ data_i[3];
        p2   = data_i[0] ^ data_i[2] ^ data_i[3];
        p4   = data_i[1] ^ data_i[2] ^ data_i[3];
        cw_o = {data_i[3], data_i[2], data_i[1], p4, data_i[0], p2, p1};
    end

endmodule

// File: rtl/ham_encoder_tx.sv
// Nibble-in, serial-out Hamming(7,4) transmitter with one-entry holding register,
// optional single-bit error injection and a wrapping completed-frame counter.
module ham_encoder_tx
    import ham_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inj_en,
    input  logic [BIT_W-1:0]  inj_pos,
    output logic [CW_W-1:0]   cw_data,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              ser_last,
    output logic [CNT_W-1:0]  frame_cnt
);

    state_e             state_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [CW_W-1:0]    hold_q;
    logic               hold_valid_q;
    logic [CW_W-1:0]    shreg_q;
    logic [CW_W-1:0]    cw_q;
    logic [CNT_W-1:0]   frame_cnt_q;

    logic [CW_W-1:0]    enc_cw;
    logic [CW_W-1:0]    inj_mask;
    logic               at_last;
    logic               load_now;
    logic               xfer;

    ham_encode_comb u_encode (
        .data_i (in_data),
        .cw_o   (enc_cw)
    );

    always_comb begin
        inj_mask = '0;
        if (inj_en && (inj_pos != NO_INJ)) begin
            inj_mask = CW_W'(1) << inj_pos;
        end
    end

    // A held word launches from IDLE, or back-to-back on the last bit of the current frame.
    assign at_last  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign load_now = hold_valid_q && ((state_q == IDLE) || at_last);
    assign in_ready = !hold_valid_q || load_now;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            cw_q         <= '0;
            frame_cnt_q  <= '0;
        end else begin
            if (xfer) begin
                hold_q       <= enc_cw ^ inj_mask;
                hold_valid_q <= 1'b1;
            end else if (load_now) begin
                hold_valid_q <= 1'b0;
            end

            if (load_now) begin
                shreg_q   <= hold_q;
                cw_q      <= hold_q;
                bit_cnt_q <= '0;
                state_q   <= SHIFT;
            end else if (state_q == SHIFT) begin
                shreg_q <= {1'b0, shreg_q[CW_W-1:1]};
                if (at_last) begin
                    state_q   <= IDLE;
                    bit_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                end
            end

            if (at_last) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ser_valid = (state_q == SHIFT);
    assign ser_out   = ser_valid && shreg_q[0];
    assign ser_first = ser_valid && (bit_cnt_q == '0);
    assign ser_last  = at_last;
    assign cw_data   = cw_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Self-checking bench for ham_encoder_tx: constant vector table, scoreboard of encoded
// words checked against the serial stream, and directed back-to-back/reset/wrap sequences.
module tb_ham_encoder_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       inj_en = 1'b0;
    logic [2:0] inj_pos = 3'd7;
    logic [6:0] cw_data;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_first;
    logic       ser_last;
    logic [7:0] frame_cnt;

    ham_encoder_tx dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
        .cw_data   (cw_data),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       en;
        logic [2:0] pos;
        logic [6:0] cw;
    } sb_t;

    typedef struct {
        logic [3:0] data;
        logic       en;
        logic [2:0] pos;
        logic [6:0] exp_cw;
        logic [2:0] exp_syn;
    } vec_t;

    sb_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder built from the generic Hamming position rule (parity k covers positions with bit k set).
    function automatic logic [6:0] enc_model(input logic [3:0] d);
        logic [6:0] c;
        int         dpos[4];
        logic       p;
        dpos = '{3, 5, 6, 7};
        c = '0;
        for (int i = 0; i < 4; i++) c[dpos[i]-1] = d[i];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int q = 1; q <= 7; q++) begin
                if ((((q >> k) & 1) == 1) && (q != (1 << k))) p = p ^ c[q-1];
            end
            c[(1 << k)-1] = p;
        end
        return c;
    endfunction

    // Reference decoder: syndrome is the 1-based position of a single flipped bit.
    function automatic logic [2:0] syn_model(input logic [6:0] c);
        logic [2:0] s;
        s = '0;
        for (int q = 1; q <= 7; q++) begin
            if (c[q-1]) s = s ^ 3'(q);
        end
        return s;
    endfunction

    function automatic logic [3:0] dec_data(input logic [6:0] c);
        logic [6:0] cc;
        logic [2:0] s;
        cc = c;
        s  = syn_model(c);
        if (s != 3'd0) cc[int'(s)-1] = ~cc[int'(s)-1];
        return {cc[6], cc[5], cc[4], cc[2]};
    endfunction

    // Monitor state
    int         bitpos = 0;
    int         frames_seen = 0;
    int         exp_frames = 0;
    int         run_len = 0;
    int         max_run = 0;
    logic [6:0] cur = '0;
    logic [6:0] cw_first = '0;
    logic [6:0] last_first_cw = '0;
    sb_t        e;
    sb_t        n;
    logic [2:0] es;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            bitpos     = 0;
            exp_frames = 0;
            run_len    = 0;
            max_run    = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ser_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                check("ser_first", 32'(ser_first), 32'(bitpos == 0));
                check("ser_last", 32'(ser_last), 32'(bitpos == 6));
                if (bitpos == 0) cw_first = cw_data;
                cur[bitpos] = ser_out;
                bitpos++;
                if (bitpos == 7) begin
                    bitpos = 0;
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e  = exp_q.pop_front();
                        es = (e.en && e.pos != 3'd7) ? e.pos + 3'd1 : 3'd0;
                        check("serial_cw", 32'(cur), 32'(e.cw));
                        check("cw_data", 32'(cw_first), 32'(e.cw));
                        check("dec_syndrome", 32'(syn_model(cur)), 32'(es));
                        check("dec_data", 32'(dec_data(cur)), 32'(e.data));
                    end
                    frames_seen++;
                    exp_frames++;
                    last_first_cw = cw_first;
                end
            end else begin
                run_len = 0;
                if (bitpos != 0) check("frame_gap", 32'(bitpos), 32'd0);
                check("idle_outs", 32'({ser_out, ser_first, ser_last}), 32'd0);
            end
            if (in_valid && in_ready) begin
                n.data = in_data;
                n.en   = inj_en;
                n.pos  = inj_pos;
                n.cw   = enc_model(in_data) ^ ((inj_en && inj_pos != 3'd7) ? (7'd1 << inj_pos) : 7'd0);
                exp_q.push_back(n);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input logic en, input logic [2:0] pos);
        bit got;
        got      = 1'b0;
        in_data  = d;
        inj_en   = en;
        inj_pos  = pos;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", 32'd0, 32'd1);
        sync();
        in_valid = 1'b0;
        inj_en   = 1'b0;
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 4000 && frames_seen < target; i++) @(negedge clk);
        check("frame_timeout", 32'(frames_seen >= target), 32'd1);
        sync();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t       vecs[11];
    logic [3:0] dvals[3];
    logic [8:0] rdy_pat;
    int         idx;
    int         start;
    bit         xf;

    initial begin
        vecs[0]  = '{4'b1011, 1'b0, 3'd7, 7'h55, 3'd0};
        vecs[1]  = '{4'b1011, 1'b1, 3'd4, 7'h45, 3'd5};
        vecs[2]  = '{4'h0,    1'b0, 3'd0, 7'h00, 3'd0};
        vecs[3]  = '{4'hF,    1'b0, 3'd0, 7'h7F, 3'd0};
        vecs[4]  = '{4'h1,    1'b0, 3'd3, 7'h07, 3'd0};
        vecs[5]  = '{4'h2,    1'b0, 3'd0, 7'h19, 3'd0};
        vecs[6]  = '{4'h4,    1'b0, 3'd0, 7'h2A, 3'd0};
        vecs[7]  = '{4'h8,    1'b0, 3'd0, 7'h4B, 3'd0};
        vecs[8]  = '{4'h0,    1'b1, 3'd0, 7'h01, 3'd1};
        vecs[9]  = '{4'hF,    1'b1, 3'd6, 7'h3F, 3'd7};
        vecs[10] = '{4'b1011, 1'b1, 3'd7, 7'h55, 3'd0};

        do_reset();
        @(negedge clk);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cw_data", 32'(cw_data), 32'd0);
        sync();

        // Table: one frame per vector, checked against hand-computed codewords
        for (int v = 0; v < 11; v++) begin
            start = frames_seen;
            send(vecs[v].data, vecs[v].en, vecs[v].pos);
            wait_until(start + 1);
            @(negedge clk);
            check("tbl_cw", 32'(last_first_cw), 32'(vecs[v].exp_cw));
            check("tbl_syndrome", 32'(syn_model(last_first_cw)), 32'(vecs[v].exp_syn));
            check("tbl_frame_cnt", 32'(frame_cnt), 32'(exp_frames & 255));
            sync();
        end

        // Back-to-back 0 then F: 14 contiguous valid cycles
        do_reset();
        start = frames_seen;
        send(4'h0, 1'b0, 3'd7);
        send(4'hF, 1'b0, 3'd7);
        wait_until(start + 2);
        @(negedge clk);
        check("b2b_run", 32'(max_run), 32'd14);
        check("b2b_frame_cnt", 32'(frame_cnt), 32'd2);
        sync();

        // in_valid held for three words: ready pattern over the first nine cycles
        do_reset();
        dvals    = '{4'h3, 4'h9, 4'hE};
        rdy_pat  = 9'b1_0000_0011;
        idx      = 0;
        start    = frames_seen;
        in_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (idx < 3) in_data = dvals[idx];
            @(negedge clk);
            check("hold_ready", 32'(in_ready), 32'(rdy_pat[c]));
            xf = in_valid && in_ready;
            sync();
            if (xf) idx++;
            if (idx >= 3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("hold_words_sent", 32'(idx), 32'd3);
        wait_until(start + 3);
        repeat (3) @(negedge clk);
        check("hold_frames", 32'(frames_seen - start), 32'd3);
        check("hold_sb_empty", 32'(exp_q.size()), 32'd0);
        sync();

        // Reset during bit 3 with a word also held
        do_reset();
        send(4'h5, 1'b0, 3'd7);
        send(4'hA, 1'b0, 3'd7);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ser_valid && ser_first) break;
        end
        repeat (3) @(negedge clk);
        check("abort_in_frame", 32'(ser_valid), 32'd1);
        #1 rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("abort_ser_valid", 32'(ser_valid), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        sync();
        @(negedge clk);
        check("abort_hold_gone", 32'(ser_valid), 32'd0);
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        sync();

        // 256 frames cycling through all nibbles: counter wraps, every word decodes clean
        do_reset();
        start = frames_seen;
        for (int i = 0; i < 256; i++) send(4'(i), 1'b0, 3'd7);
        wait_until(start + 256);
        @(negedge clk);
        check("wrap_frames", 32'(frames_seen - start), 32'd256);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
        sync();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
